// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time over a
// req/gnt/rvalid handshake and presents the fetched word to the IF->ID register.
// Responses that belong to a request overtaken by a redirect are dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        InstrValidF
);

    // REQ: request outstanding on the bus; WAIT: accepted, awaiting data;
    // HOLD: word presented downstream; DRAIN: awaiting a response we will discard.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_buf_reg, instr_buf_next;
    logic [31:0] target;

    // Redirect targets are word-aligned by construction.
    assign target = {PCTargetE[31:2], 2'b00};

    // State, PC and instruction buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_REQ;
            pc_reg        <= {RESET_PC[31:2], 2'b00};
            instr_buf_reg <= NOP_INSTR;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            instr_buf_reg <= instr_buf_next;
        end
    end

    // Next-state logic; a redirect always takes precedence over a stall.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        instr_buf_next = instr_buf_reg;
        case (state_reg)
            S_REQ: begin
                // rvalid here would be a protocol violation and is ignored.
                if (PCSrcE) begin
                    pc_next    = target;
                    state_next = imem_gnt ? S_DRAIN : S_REQ;
                end else if (imem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pc_next    = target;
                    // If the data arrives with the redirect it is simply discarded.
                    state_next = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    instr_buf_next = imem_rdata;
                    state_next     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    pc_next    = target;
                    state_next = S_REQ;
                end else if (!StallF) begin
                    pc_next    = pc_reg + 32'd4;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (PCSrcE) begin
                    pc_next = target;
                end
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // Outputs decode directly from registers; rdata never reaches InstrF combinationally.
    assign imem_req    = (state_reg == S_REQ) && !reset;
    assign imem_addr   = pc_reg;
    assign PCF         = pc_reg;
    assign PCPlus4F    = pc_reg + 32'd4;
    assign InstrValidF = (state_reg == S_HOLD);
    assign InstrF      = (state_reg == S_HOLD) ? instr_buf_reg : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: inputs change 1ns after each rising edge,
// outputs are checked at the same point, before new inputs are applied.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        InstrValidF;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrF(InstrF), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .InstrValidF(InstrValidF)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got=%h exp=00000000", PCF); end
        checks++; if (InstrF !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", InstrF, NOP); end
        checks++; if (InstrValidF !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", InstrValidF); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_release_req got=%b exp=1", imem_req); end
        $display("reset: released, pc=%h", PCF);
    endtask

    // Fetch three words back to back with gnt held high.
    task automatic test_basic_fetch();
        logic [31:0] words [3];
        logic [31:0] pc;
        words[0] = 32'h0050_0093; words[1] = 32'h00A0_0113; words[2] = 32'h0020_81B3;
        imem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(i * 4);
            checks++; if (imem_req !== 1'b1 || imem_addr !== pc) begin errors++;
                $display("FAIL fetch_req[%0d] got req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, pc); end
            tick();
            checks++; if (imem_req !== 1'b0 || InstrValidF !== 1'b0) begin errors++;
                $display("FAIL fetch_wait[%0d] got req=%b valid=%b exp req=0 valid=0", i, imem_req, InstrValidF); end
            imem_rvalid = 1'b1; imem_rdata = words[i];
            tick();
            imem_rvalid = 1'b0;
            checks++; if (InstrValidF !== 1'b1 || InstrF !== words[i]) begin errors++;
                $display("FAIL fetch_hold[%0d] got valid=%b instr=%h exp valid=1 instr=%h", i, InstrValidF, InstrF, words[i]); end
            checks++; if (PCF !== pc || PCPlus4F !== pc + 32'd4) begin errors++;
                $display("FAIL fetch_pc[%0d] got pcf=%h pc4=%h exp pcf=%h pc4=%h", i, PCF, PCPlus4F, pc, pc + 32'd4); end
            $display("fetch: pc=%h instr=%h valid=%b", PCF, InstrF, InstrValidF);
            tick();
        end
        imem_gnt = 1'b0;
    endtask

    // Hold a fetched word for four stalled cycles, then release.
    task automatic test_stall();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
        tick();
        imem_rvalid = 1'b0; StallF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'h00A0_0093 || PCF !== 32'hC || imem_req !== 1'b0) begin errors++;
                $display("FAIL stall_hold[%0d] got valid=%b instr=%h pcf=%h req=%b exp valid=1 instr=00a00093 pcf=0000000c req=0",
                         i, InstrValidF, InstrF, PCF, imem_req); end
        end
        StallF = 1'b0;
        tick();
        checks++; if (PCF !== 32'h10 || imem_req !== 1'b1 || InstrValidF !== 1'b0) begin errors++;
            $display("FAIL stall_release got pcf=%h req=%b valid=%b exp pcf=00000010 req=1 valid=0", PCF, imem_req, InstrValidF); end
        $display("stall: released, next pc=%h", PCF);
    endtask

    // Redirect while waiting for data: the late response must be dropped.
    task automatic test_redirect_drain();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
        tick();
        PCSrcE = 1'b0;
        checks++; if (PCF !== 32'h100 || imem_req !== 1'b0 || InstrValidF !== 1'b0) begin errors++;
            $display("FAIL drain_enter got pcf=%h req=%b valid=%b exp pcf=00000100 req=0 valid=0", PCF, imem_req, InstrValidF); end
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_wait_req got=%b exp=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (InstrValidF !== 1'b0 || InstrF !== NOP) begin errors++;
            $display("FAIL drain_stale got valid=%b instr=%h exp valid=0 instr=%h", InstrValidF, InstrF, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++;
            $display("FAIL drain_reissue got req=%b addr=%h exp req=1 addr=00000100", imem_req, imem_addr); end
        $display("drain: stale word dropped, refetch addr=%h", imem_addr);
    endtask

    // Redirect and stall together in HOLD: redirect wins.
    task automatic test_redirect_over_stall();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'h1234_5678) begin errors++;
            $display("FAIL prio_hold got valid=%b instr=%h exp valid=1 instr=12345678", InstrValidF, InstrF); end
        StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
        tick();
        StallF = 1'b0; PCSrcE = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || InstrValidF !== 1'b0 || InstrF !== NOP) begin errors++;
            $display("FAIL prio_redirect got req=%b addr=%h valid=%b instr=%h exp req=1 addr=00000200 valid=0 instr=%h",
                     imem_req, imem_addr, InstrValidF, InstrF, NOP); end
        $display("priority: redirect to %h over stall", imem_addr);
    endtask

    // No grant for five cycles, then a redirect while still ungranted.
    task automatic test_no_grant();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || InstrF !== NOP || InstrValidF !== 1'b0) begin errors++;
                $display("FAIL nogrant[%0d] got req=%b addr=%h instr=%h valid=%b exp req=1 addr=00000200 instr=%h valid=0",
                         i, imem_req, imem_addr, InstrF, InstrValidF, NOP); end
        end
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0302;
        tick();
        PCSrcE = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++;
            $display("FAIL nogrant_redirect got req=%b addr=%h exp req=1 addr=00000300", imem_req, imem_addr); end
        $display("nogrant: request retargeted to %h", imem_addr);
    endtask

    // PC at the top of the address space wraps to zero.
    task automatic test_wrap();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        PCSrcE = 1'b0;
        checks++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin errors++;
            $display("FAIL wrap_pc4 got pcf=%h pc4=%h exp pcf=fffffffc pc4=00000000", PCF, PCPlus4F); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0073;
        tick();
        imem_rvalid = 1'b0;
        tick();
        checks++; if (PCF !== 32'h0 || imem_req !== 1'b1) begin errors++;
            $display("FAIL wrap_advance got pcf=%h req=%b exp pcf=00000000 req=1", PCF, imem_req); end
        $display("wrap: pc=%h", PCF);
    endtask

    // Redirect together with grant, then reset asserted asynchronously in WAIT.
    task automatic test_async_reset();
        imem_gnt = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0040;
        tick();
        imem_gnt = 1'b0; PCSrcE = 1'b0;
        checks++; if (PCF !== 32'h40 || imem_req !== 1'b0) begin errors++;
            $display("FAIL gnt_redirect got pcf=%h req=%b exp pcf=00000040 req=0", PCF, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (PCF !== 32'h0 || InstrValidF !== 1'b0 || imem_req !== 1'b0) begin errors++;
            $display("FAIL async_reset got pcf=%h valid=%b req=%b exp pcf=00000000 valid=0 req=0", PCF, InstrValidF, imem_req); end
        tick();
        reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_0000;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || InstrValidF !== 1'b0) begin errors++;
            $display("FAIL reset_stale got req=%b addr=%h valid=%b exp req=1 addr=00000000 valid=0", imem_req, imem_addr, InstrValidF); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (InstrValidF !== 1'b1 || InstrF !== 32'h0010_0093 || PCF !== 32'h0) begin errors++;
            $display("FAIL reset_refetch got valid=%b instr=%h pcf=%h exp valid=1 instr=00100093 pcf=00000000", InstrValidF, InstrF, PCF); end
        $display("async reset: refetched instr=%h at pc=%h", InstrF, PCF);
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect_drain();
        test_redirect_over_stall();
        test_no_grant();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
